// File: rtl/single_read_single_write_fifo.sv
// Synchronous FIFO: enqueue on write_enable, dequeue into a registered read_data.
// Sticky overflow/underflow flags record rejected writes and reads.
module single_read_single_write_fifo #(
   parameter int width      = 16,
   parameter int depth      = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [width-1:0]      write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [width-1:0]      read_data,
   output logic                  full,
   output logic                  empty,
   output logic [addr_width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [addr_width:0]   count_depth = (addr_width+1)'(depth);
   localparam logic [addr_width:0]   count_one   = (addr_width+1)'(1);
   localparam logic [addr_width-1:0] ptr_one     = addr_width'(1);

   logic [width-1:0]      mem [depth];
   logic [addr_width-1:0] wptr;
   logic [addr_width-1:0] rptr;
   logic [addr_width:0]   count_next;
   logic                  wr_accept;
   logic                  rd_accept;

   // full/empty are the registered pre-edge values, so a simultaneous
   // write into an empty FIFO can never fall through to read_data.
   assign wr_accept = write_enable & ~full;
   assign rd_accept = read_enable & ~empty;

   always_comb begin
      count_next = count;
      case ({wr_accept, rd_accept})
         2'b10:   count_next = count + count_one;
         2'b01:   count_next = count - count_one;
         default: count_next = count;
      endcase
   end

   // NOTE: storage has no reset so it maps onto RAM; stale words are unreachable
   // because both pointers restart at zero.
   always_ff @(posedge clk) begin
      if (!reset && wr_accept) begin
         mem[wptr] <= write_data;
      end
   end

   // NOTE: all state registers use non-blocking assignments so every update
   // below sees pre-edge values of full, empty and count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         read_data <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + ptr_one;
         end
         if (rd_accept) begin
            read_data <= mem[rptr];
            rptr      <= rptr + ptr_one;
         end
         if (write_enable && full) begin
            overflow <= 1'b1;
         end
         if (read_enable && empty) begin
            underflow <= 1'b1;
         end
         count <= count_next;
         full  <= (count_next == count_depth);
         empty <= (count_next == '0);
      end
   end

endmodule

// File: doc/single_read_single_write_fifo.md
Name: single_read_single_write_fifo

Overview:
- Synchronous FIFO built on the single-read/single-write register idea, adding an explicit read side.
- The write port keeps the existing convention: write_data qualified by write_enable.
- The read port pops entries in order into a registered read_data output.
- Used as the buffering stage between a producer that writes registers and a consumer that drains them one word per cycle.

Parameters:
width, 16, data word width in bits
depth, 8, number of entries; must be a power of 2, minimum 2
addr_width, 3, pointer width; must equal log2(depth)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
write_data  input  width  data to enqueue
write_enable  input  1  enqueue request, sampled at the rising edge of clk
read_enable  input  1  dequeue request, sampled at the rising edge of clk
read_data  output  width  registered output of the most recently dequeued entry
full  output  1  high when count == depth
empty  output  1  high when count == 0
count  output  addr_width+1  number of stored entries, 0..depth
overflow  output  1  sticky; set on any write attempt while full
underflow  output  1  sticky; set on any read attempt while empty

Behaviour:
- Reset: on a clk edge with reset=1, regardless of other inputs:
  - write pointer = 0, read pointer = 0, count = 0;
  - empty=1, full=0, read_data=0, overflow=0, underflow=0;
  - storage array is not cleared; its contents are unreachable until rewritten.
- Reset mid-operation: any write or read presented in the reset cycle is discarded. Operation resumes on the first edge with reset=0.
- Write accept = write_enable & ~full, where full is the value before the edge.
  - On accept: mem[wptr] <= write_data; wptr <= wptr+1, wrapping depth-1 -> 0 via natural addr_width overflow.
- Read accept = read_enable & ~empty, where empty is the value before the edge.
  - On accept: read_data <= mem[rptr]; rptr <= rptr+1 with the same wrap.
  - Latency: data appears on read_data one edge after the accepted read_enable.
  - read_data holds its last value when no read is accepted.
- Count update per edge:
  - +1 for write only;
  - -1 for read only;
  - unchanged when both or neither are accepted.
- full and empty are registered, updated in the same edge as count, and never both high.
- Simultaneous read and write:
  - neither full nor empty: both accepted; count unchanged; order preserved.
  - full: read accepted, write rejected; count = depth-1; overflow set.
  - empty: write accepted, read rejected, with no fall-through of the same-cycle write; count = 1; underflow set; read_data unchanged.
- Rejected write: storage and wptr unchanged; overflow <= 1.
- Rejected read: read_data and rptr unchanged; underflow <= 1.
- overflow and underflow are cleared only by reset.
- Single read_data port; no combinational path from write_data to read_data.

Test Plan:
- Reset then idle: reset=1 for 1 edge -> count=0, empty=1, full=0, read_data=0, both error flags 0. Remain unchanged with both enables low for 3 edges.
- Ordered transfer: write 25, 50, 75 on three edges -> count=3. Then read_enable for three edges -> read_data = 25, 50, 75 on successive edges; empty=1 afterwards.
- Fill, overflow and wrap:
  - Write 1..8 -> full=1, count=8.
  - Write 99 -> rejected, overflow=1, count stays 8.
  - Read 8 entries -> 1..8 in order.
  - Write 9,10 then read -> 9,10, confirming pointer wrap.
- Underflow: from empty, read_enable=1 -> underflow=1, read_data holds its previous value, count=0.
- Simultaneous edges:
  - count=4, both enables high with write_data=40 -> count stays 4; read returns the oldest entry; 40 later emerges in order.
  - Full plus both -> count=7, overflow=1.
  - Empty plus both with write_data=5 -> count=1, underflow=1; a following read returns 5.
- Reset mid-operation: with count=5, assert reset alongside write_enable=1 and write_data=123 -> next state count=0, empty=1, read_data=0, flags 0. A subsequent read without a write sets underflow (123 was discarded).
